// File: rtl/sub_pkg.sv
// Shared encodings and defaults for the bit-serial subtractor.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SUB_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell; purely combinational, no handshake.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a-b (LSB first) on one full adder; borrow/ovf flags exist only with SUB_FLAGS_EN.
// Done pulses WIDTH+1 cycles after accept; start is ignored unless IDLE (no queuing).
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff
`ifdef SUB_FLAGS_EN
  ,
  output logic             borrow,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             fa_s, fa_cout;
`ifdef SUB_FLAGS_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;
`endif

  // Subtraction as a + ~b + 1: invert b here, carry seeded to 1 on accept.
  full_adder u_fa (
    .a    (sa_q[0]),
    .b    (~sb_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
`ifdef SUB_FLAGS_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          carry_d = 1'b1;
          cnt_d   = '0;
`ifdef SUB_FLAGS_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d = fa_cout;
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          // Publish the register including the bit being produced this cycle.
          diff_d  = res_d;
`ifdef SUB_FLAGS_EN
          borrow_d = ~fa_cout;
          ovf_d    = (a_msb_q != b_msb_q) && (fa_s != a_msb_q);
`endif
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
`ifdef SUB_FLAGS_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
`ifdef SUB_FLAGS_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  // Handshake outputs decode the state register directly, so they stay glitch-free.
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign diff = diff_q;
`ifdef SUB_FLAGS_EN
  assign borrow = borrow_q;
  assign ovf    = ovf_q;
`endif

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

- Bit-serial WIDTH-bit two's-complement subtractor.
- Computes diff = a − b one bit per clock, LSB first, using a single full-adder cell with b inverted and carry-in forced to 1.
- Serves as the area-cheap inverse-operation companion to the parallel ripple adders in the arithmetic lab datapath.
- Wrapped in a start/busy/done handshake so a controller can issue subtractions back-to-back.

## Interface
- WIDTH, 8, operand and result width in bits (≥2).
- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend, captured on the accepting edge.
- b  input  WIDTH  subtrahend, captured on the accepting edge.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; result valid.
- diff  output  WIDTH  result (a − b) mod 2^WIDTH; held until the next result completes.
- borrow  output  1  (SUB_FLAGS_EN only) high when unsigned a < b.
- ovf  output  1  (SUB_FLAGS_EN only) signed overflow.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- **IDLE, start=1:** load sa←a, sb←b, carry←1, bit counter←0, go to RUN. **IDLE, start=0:** stay in IDLE.
- **RUN, each cycle:**
  - s = sa[0] ^ ~sb[0] ^ carry.
  - carry ← majority(sa[0], ~sb[0], carry).
  - sa and sb shift right by one.
  - s shifts into the MSB of the result shift register.
  - counter increments.
- **RUN, last bit:** after the bit with counter = WIDTH−1 is processed, copy the result register to diff and go to DONE.
- **DONE:** done=1 for exactly one cycle, then go to IDLE unconditionally.
- start is ignored in RUN and DONE; there is no queuing. A request is accepted only in IDLE.
- a and b may change freely after the accepting edge.
- Arithmetic is modulo 2^WIDTH; no saturation.
- The final carry out is inverted to give the borrow.
- **Reset (rst_n=0 at an edge), from any state including mid-RUN:**
  - state → IDLE.
  - busy=0, done=0, diff=0, borrow=0, ovf=0.
  - shift registers, carry and counter cleared.
  - An in-flight operation is discarded and never signals done.

## Timing
- Accepting edge E0: busy=1 from E0.
- Bits are processed at edges E1..E(WIDTH).
- diff and flags are updated at E(WIDTH); done=1 and busy=0 during the cycle after E(WIDTH).
- The FSM returns to IDLE at E(WIDTH+1).
- The earliest next accept is E(WIDTH+2), so throughput is one result per WIDTH+2 cycles.
- Latency from the accepting edge to done is WIDTH+1 cycles (9 for WIDTH=8).
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- SUB_FLAGS_EN defined:
  - borrow and ovf ports exist.
  - Both are registered at E(WIDTH) alongside diff and held with it.
  - ovf = (a[MSB] ≠ b[MSB]) & (diff[MSB] ≠ a[MSB]); a[MSB] and b[MSB] are captured at accept.
- SUB_FLAGS_EN undefined:
  - Both ports and their logic are absent.
  - diff and handshake behaviour are unchanged.

## Structure
- The shared package `sub_pkg` holds:
  - the state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the default width constant (8).
- The bit-cell logic is the team's existing `full_adder` cell, instantiated once.
  - Its inputs are sa[0], ~sb[0] and carry; its outputs are s and the next carry.
- The FSM, counter (width $clog2(WIDTH)+1) and shift registers live in the top module.

## Test plan
- **Basic subtraction:** reset, then a=8'd100, b=8'd37, start=1 for one cycle → busy for 8 cycles, then done pulse 9 cycles after accept, diff=8'd63, borrow=0, ovf=0.
- **Wrap-around:** a=8'h00, b=8'h01 → diff=8'hFF, borrow=1, ovf=0.
- **Signed overflow:** a=8'h80, b=8'h01 → diff=8'h7F, ovf=1, borrow=0.
- **Start while busy:** hold start=1 and change a/b in cycle 3 of RUN → result matches the first operands only; start held through DONE is ignored, and the next accept occurs at the IDLE edge.
- **Reset mid-operation:** rst_n=0 for one edge at RUN bit 4 → busy=0, diff=0, no done pulse. A new request then gives the correct result (a=8'd5, b=8'd5 → diff=0).
- **Back-to-back requests:** two requests, 8'd200−8'd56 then 8'd1−8'd2 → diff=8'd144, then diff=8'hFF with borrow=1. The done pulses are exactly 10 cycles apart.
